ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.

---
 rtl/ps2_host_tx.sv | 160 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving both lines open-drain via *_oe.
// Optional macro PS2_TX_RETRY_EN: resend the latched byte once after a NACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);
  // state     | meaning
  // IDLE      | lines released, ready for a byte
  // INHIBIT   | hold ps2_clk low to claim the bus
  // REQ       | start bit: data low while clk still held
  // SEND      | device clocks; drive data, parity, stop on falling edges
  // ACK       | sample the device ack bit on the 11th falling edge
  // WAIT_IDLE | wait for both lines high, then report the result
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  localparam int MAX_CYC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TIMEOUT_CYC - 1);

  state_t        state, state_nxt, fail_nxt;
  logic          clk_s1, clk_s2, clk_last, dat_s1, dat_s2;
  logic          fe, timed, timeout, line_idle, retry_avail;
  logic [CW-1:0] tmr;
  logic [9:0]    frame;
  logic [3:0]    n;
  logic          drive_q, ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_last <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_last <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fe        = clk_last & ~clk_s2;
  assign timed     = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
  assign timeout   = timed && (tmr == '0) && !fe;
  assign line_idle = clk_s2 && dat_s2;

`ifdef PS2_TX_RETRY_EN
  logic retry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 1'b0;
    end else if (state == S_IDLE) begin
      retry_q <= 1'b0;
    end else if (state_nxt == S_INHIBIT) begin
      retry_q <= 1'b1;
    end
  end

  assign retry_avail = !retry_q;
`else
  assign retry_avail = 1'b0;
`endif

  assign fail_nxt = retry_avail ? S_INHIBIT : S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (tx_valid) state_nxt = S_INHIBIT;
      S_INHIBIT:   if (tmr == '0) state_nxt = S_REQ;
      S_REQ:       state_nxt = S_SEND;
      S_SEND: begin
        if (timeout)               state_nxt = fail_nxt;
        else if (fe && n == 4'd9)  state_nxt = S_ACK;
      end
      S_ACK: begin
        if (timeout)  state_nxt = fail_nxt;
        else if (fe)  state_nxt = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (timeout)        state_nxt = fail_nxt;
        else if (line_idle) state_nxt = ack_q ? S_IDLE : fail_nxt;
      end
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Timeout output also masks data_oe so the line is released in the timeout cycle itself.
  always_comb begin
    tx_ready    = (state == S_IDLE);
    busy        = (state != S_IDLE);
    ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
    ps2_data_oe = (state == S_REQ) || ((state == S_SEND) && drive_q && !timeout);
    tx_done     = (state == S_WAIT_IDLE) && line_idle && !timeout && ack_q;
    tx_err      = !retry_avail &&
                  (timeout || ((state == S_WAIT_IDLE) && line_idle && !ack_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame   <= '0;
      n       <= '0;
      drive_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        drive_q <= 1'b0;
        n       <= '0;
        if (tx_valid) frame <= {1'b1, ~^tx_data, tx_data};
      end
      if (state == S_REQ) begin
        drive_q <= 1'b1;
        n       <= '0;
      end
      if (state == S_SEND && fe) begin
        drive_q <= ~frame[n];
        if (n != 4'd10) n <= n + 4'd1;
      end
      if (state == S_ACK && fe) ack_q <= ~dat_s2;
    end
  end

  // Down-counter: inhibit length in INHIBIT, inter-edge timeout in the timed states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state_nxt != state) begin
      tmr <= (state_nxt == S_INHIBIT) ? INH_LOAD : TO_LOAD;
    end else if (timed && fe) begin
      tmr <= TO_LOAD;
    end else if (tmr != '0) begin
      tmr <= tmr - CW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a behavioural PS/2 keyboard model.
// Expected frames/outcomes are queued at issue time and checked by independent monitors.
module tb_ps2_host_tx;
  localparam int INH    = 20;
  localparam int TO     = 2000;
  localparam int HALF   = 50;
  localparam int LIMIT  = 12000;
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_l, ps2_data_l;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [9:0] exp_frames[$];
  logic [1:0] exp_out[$];
  int         dev_modes[$];

  assign ps2_clk_l  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_l = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk_l), .ps2_data(ps2_data_l),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame as the device should see it: data LSB first, odd parity, stop.
  function automatic logic [9:0] ref_frame(input logic [7:0] d);
    logic par;
    par = (($countones(d) % 2) == 0);
    return {1'b1, par, d};
  endfunction

  // {done, err} expected for the given device behaviour on each attempt.
  function automatic logic [1:0] ref_outcome(input int m0, input int m1);
`ifdef PS2_TX_RETRY_EN
    return (m0 == M_ACK || m1 == M_ACK) ? 2'b10 : 2'b01;
`else
    if (m1 == M_ACK) return (m0 == M_ACK) ? 2'b10 : 2'b01;
    return (m0 == M_ACK) ? 2'b10 : 2'b01;
`endif
  endfunction

  initial begin : device
    int mode;
    logic [9:0] got, exp;
    forever begin
      @(negedge clk);
      if (rst_n && ps2_clk_l && !ps2_data_l) begin
        mode = M_ACK;
        if (dev_modes.size() != 0) mode = dev_modes.pop_front();
        if (mode == M_SILENT) begin
          while (!ps2_data_l) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
          for (int k = 0; k < 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            got[k] = ps2_data_l;
            repeat (HALF) @(negedge clk);
          end
          if (exp_frames.size() == 0) begin
            check("frame_expected", exp_frames.size(), 1);
          end else begin
            exp = exp_frames[0];
            check("frame_data", int'(got[7:0]), int'(exp[7:0]));
            check("frame_parity", int'(got[8]), int'(exp[8]));
            check("frame_stop", int'(got[9]), 1);
          end
          if (mode == M_ACK) dev_data_low = 1'b1;
          repeat (HALF / 2) @(negedge clk);
          dev_clk_low = 1'b1;
          repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (HALF / 2) @(negedge clk);
          dev_data_low = 1'b0;
          repeat (HALF / 2) @(negedge clk);
        end
      end
    end
  end

  initial begin : out_mon
    logic [1:0] eo;
    forever begin
      @(negedge clk);
      if (rst_n && (tx_done || tx_err)) begin
        if (tx_done) done_cnt++;
        if (tx_err)  err_cnt++;
        check("ready_in_pulse", int'(tx_ready), 0);
        if (exp_out.size() == 0) begin
          check("pulse_expected", exp_out.size(), 1);
        end else begin
          eo = exp_out.pop_front();
          check("outcome", int'({tx_done, tx_err}), int'(eo));
        end
        @(negedge clk);
        check("ready_after_pulse", int'(tx_ready), 1);
      end
    end
  end

  task automatic send(input logic [7:0] d, input int m0, input int m1, input bit hold,
                      output int req_cyc, output int pulse_cyc);
    int b, inh_run, phases, exp_ph, d0, e0;
    logic [1:0] eo;
    bit busy_drop, seen;
    b = 0;
    while (!tx_ready && b < LIMIT) begin
      @(negedge clk);
      b++;
    end
    check("ready_before_send", int'(tx_ready), 1);
    exp_ph = 1;
    exp_frames.push_back(ref_frame(d));
    dev_modes.push_back(m0);
`ifdef PS2_TX_RETRY_EN
    if (m0 != M_ACK) begin
      dev_modes.push_back(m1);
      exp_ph = 2;
    end
`endif
    eo = ref_outcome(m0, (exp_ph == 2) ? m1 : m0);
    exp_out.push_back(eo);
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    b = 0; inh_run = 0; phases = 0; req_cyc = 0; pulse_cyc = 0;
    busy_drop = 1'b0; seen = 1'b0;
    while (b < LIMIT && !seen) begin
      if (ps2_clk_oe && !ps2_data_oe) begin
        if (inh_run == 0) phases++;
        inh_run++;
      end else if (inh_run != 0) begin
        check("inhibit_len", inh_run, INH);
        inh_run = 0;
      end
      if (ps2_clk_oe && ps2_data_oe) req_cyc = b;
      if (tx_done || tx_err) begin
        pulse_cyc = b;
        seen = 1'b1;
        check("released_at_pulse", int'({ps2_clk_oe, ps2_data_oe}), 0);
      end else begin
        if (!busy) busy_drop = 1'b1;
        if (hold) tx_data = 8'($urandom);
        @(negedge clk);
        b++;
      end
    end
    tx_valid = 1'b0;
    check("outcome_seen", int'(seen), 1);
    check("busy_held", int'(busy_drop), 0);
    check("inhibit_phases", phases, exp_ph);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, eo[1] ? 1 : 0);
    check("err_pulses", err_cnt - e0, eo[0] ? 1 : 0);
    check("queue_drained", exp_out.size(), 0);
    if (exp_frames.size() != 0) void'(exp_frames.pop_front());
    exp_out.delete();
    repeat (HALF) @(negedge clk);
  endtask

  initial begin : main
    int rq, pc, b;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_data_oe", int'(ps2_data_oe), 0);
    check("rst_done", int'(tx_done), 0);
    check("rst_err", int'(tx_err), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset asserted while the frame is in SEND.
    dev_modes.push_back(M_SILENT);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    b = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && b < 200) begin
      @(negedge clk);
      b++;
    end
    repeat (50) @(negedge clk);
    check("busy_in_send", int'(busy), 1);
    check("data_oe_in_send", int'(ps2_data_oe), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_clk_oe", int'(ps2_clk_oe), 0);
    check("midrst_data_oe", int'(ps2_data_oe), 0);
    check("midrst_ready", int'(tx_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    dev_modes.delete();

    send(8'hED, M_ACK, M_ACK, 1'b0, rq, pc);
    send(8'h00, M_NACK, M_NACK, 1'b0, rq, pc);
    send(8'hF4, M_SILENT, M_SILENT, 1'b0, rq, pc);
    check("timeout_latency", pc - rq, TO);
    send(8'hFF, M_ACK, M_ACK, 1'b1, rq, pc);
`ifdef PS2_TX_RETRY_EN
    send(8'h3C, M_NACK, M_ACK, 1'b0, rq, pc);
`endif
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK, M_ACK, 1'b0, rq, pc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
